// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the writeback-trace checker.
//   state_e       : checker state (run / pass / fail)
//   fail_code_e   : value reported on fail_code and in the fail LED pattern
//   LED_RUN/PASS  : board LED patterns for the non-fail states
//   trace_entry_t : field layout of one trace-memory word at default widths
//   fail_leds()   : LED pattern for the fail state
package wb_trace_pkg;

    typedef enum logic [1:0] {
        StRun,
        StPass,
        StFail
    } state_e;

    typedef enum logic [2:0] {
        FcNone     = 3'd0,
        FcMismatch = 3'd1,
        FcOverrun  = 3'd2,
        FcShort    = 3'd3,
        FcTimeout  = 3'd4
    } fail_code_e;

    localparam logic [15:0] LED_RUN  = 16'hFFFF;
    localparam logic [15:0] LED_PASS = 16'h0000;

    localparam int unsigned TE_PC_W   = 32;
    localparam int unsigned TE_ADDR_W = 8;
    localparam int unsigned TE_DATA_W = 32;

    typedef struct packed {
        logic [TE_PC_W-1:0]   pc;
        logic [TE_ADDR_W-1:0] addr;
        logic [TE_DATA_W-1:0] data;
    } trace_entry_t;

    function automatic logic [15:0] fail_leds(fail_code_e code, logic [7:0] err_lo);
        return {5'b0, code, err_lo};
    endfunction

endpackage

// File: rtl/wb_trace_cmp.sv
// Writeback-vs-trace comparator.
//   clk, reset            : clock, async active-high reset
//   valid                 : a writeback is being checked this cycle
//   err_none              : no mismatch recorded so far
//   wb_pc/rf_addr/wdata   : observed writeback
//   exp_pc/addr/data      : trace entry fields (addr zero-padded to 8 bits)
//   match, mismatch       : result for this cycle (qualified by valid)
//   capture               : first mismatch of the run, latch the error fields
//   mismatch_q            : mismatch registered, used for the delayed stop-on-error
module wb_trace_cmp #(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic                 err_none,
    input  logic [PC_W-1:0]      wb_pc,
    input  logic [RF_ADDR_W-1:0] wb_rf_addr,
    input  logic [DATA_W-1:0]    wb_rf_wdata,
    input  logic [PC_W-1:0]      exp_pc,
    input  logic [7:0]           exp_addr,
    input  logic [DATA_W-1:0]    exp_data,
    output logic                 match,
    output logic                 mismatch,
    output logic                 capture,
    output logic                 mismatch_q
);

    logic same;

    assign same     = (wb_pc == exp_pc) && (8'(wb_rf_addr) == exp_addr)
                      && (wb_rf_wdata == exp_data);
    assign match    = valid && same;
    assign mismatch = valid && !same;
    assign capture  = mismatch && err_none;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch;
        end
    end

endmodule

// File: rtl/wb_trace_checker.sv
// Writeback-trace checker: compares each register-file writeback against an
// external, combinationally read trace memory and reports pass/fail.
// Optional stall timeout enabled by defining WB_TRACE_CHECKER_TIMEOUT_EN.
//   clk, reset     : clock, async active-high reset
//   wb_*           : CPU debug writeback (pc, enable, register, data)
//   trace_idx      : address of the trace entry being compared
//   trace_entry    : {pc, 8-bit zero-padded addr, data} at trace_idx
//   done/pass/fail : terminal status; fail_code gives the reason
//   match_count    : matched writebacks; err_count: mismatches (saturating)
//   err_pc/addr/wdata : first mismatching writeback
//   leds           : board status pattern
module wb_trace_checker
    import wb_trace_pkg::*;
#(
    parameter int unsigned    TRACE_DEPTH    = 16,
    parameter int unsigned    PC_W           = 32,
    parameter int unsigned    DATA_W         = 32,
    parameter int unsigned    RF_ADDR_W      = 5,
    parameter logic [PC_W-1:0] END_PC        = 32'h0000006c,
    parameter int unsigned    STOP_ON_ERR    = 1,
    parameter int unsigned    STRICT_COUNT   = 1,
    parameter int unsigned    TIMEOUT_CYCLES = 4096,
    localparam int unsigned   IDX_W          = $clog2(TRACE_DEPTH + 1),
    localparam int unsigned   ENTRY_W        = PC_W + 8 + DATA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PC_W-1:0]      wb_pc,
    input  logic                 wb_rf_wen,
    input  logic [RF_ADDR_W-1:0] wb_rf_addr,
    input  logic [DATA_W-1:0]    wb_rf_wdata,
    output logic [IDX_W-1:0]     trace_idx,
    input  logic [ENTRY_W-1:0]   trace_entry,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic [2:0]           fail_code,
    output logic [15:0]          match_count,
    output logic [15:0]          err_count,
    output logic [PC_W-1:0]      err_pc,
    output logic [RF_ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0]    err_wdata,
    output logic [15:0]          leds
);

    state_e               state_q;
    fail_code_e           code_q, end_code;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [15:0]          mc_q, mc_d, ec_q, ec_d, leds_q;
    logic [PC_W-1:0]      err_pc_q;
    logic [RF_ADDR_W-1:0] err_addr_q;
    logic [DATA_W-1:0]    err_wdata_q;
    logic                 pass_q, fail_q, done_q;

    logic in_run, wb_event, end_hit, at_end, overrun, tmo_hit, consume, stop_hit, end_ok;
    logic cmp_match, cmp_mismatch, cmp_capture, cmp_mismatch_q;

    assign in_run   = (state_q == StRun);
    assign wb_event = in_run && wb_rf_wen && (wb_rf_addr != '0);
    assign end_hit  = in_run && (wb_pc == END_PC);
    assign at_end   = (idx_q == IDX_W'(TRACE_DEPTH));
    assign overrun  = wb_event && at_end;
    // Only writebacks not pre-empted by a higher-priority outcome are compared.
    assign consume  = wb_event && !end_hit && !overrun && !tmo_hit;
    // A mismatch seen last cycle terminates the run one edge later.
    assign stop_hit = in_run && (STOP_ON_ERR != 0) && cmp_mismatch_q;
    assign end_ok   = (ec_q == '0) && ((STRICT_COUNT == 0) || at_end);

`ifdef WB_TRACE_CHECKER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;

    assign tmo_hit = in_run && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else if (wb_event) begin
            tmo_cnt_q <= '0;
        end else if (in_run && !tmo_hit) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    wb_trace_cmp #(
        .PC_W      (PC_W),
        .DATA_W    (DATA_W),
        .RF_ADDR_W (RF_ADDR_W)
    ) u_cmp (
        .clk         (clk),
        .reset       (reset),
        .valid       (consume),
        .err_none    (ec_q == '0),
        .wb_pc       (wb_pc),
        .wb_rf_addr  (wb_rf_addr),
        .wb_rf_wdata (wb_rf_wdata),
        .exp_pc      (trace_entry[ENTRY_W-1 -: PC_W]),
        .exp_addr    (trace_entry[DATA_W +: 8]),
        .exp_data    (trace_entry[DATA_W-1:0]),
        .match       (cmp_match),
        .mismatch    (cmp_mismatch),
        .capture     (cmp_capture),
        .mismatch_q  (cmp_mismatch_q)
    );

    always_comb begin
        idx_d    = idx_q;
        mc_d     = mc_q;
        ec_d     = ec_q;
        end_code = (ec_q != '0) ? FcMismatch : FcShort;
        if (consume) begin
            idx_d = idx_q + IDX_W'(1);
        end
        if (cmp_match) begin
            mc_d = mc_q + 16'd1;
        end
        if (cmp_mismatch && (ec_q != 16'hFFFF)) begin
            ec_d = ec_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StRun;
            code_q      <= FcNone;
            idx_q       <= '0;
            mc_q        <= '0;
            ec_q        <= '0;
            err_pc_q    <= '0;
            err_addr_q  <= '0;
            err_wdata_q <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            done_q      <= 1'b0;
            leds_q      <= LED_RUN;
        end else begin
            idx_q <= idx_d;
            mc_q  <= mc_d;
            ec_q  <= ec_d;
            if (cmp_capture) begin
                err_pc_q    <= wb_pc;
                err_addr_q  <= wb_rf_addr;
                err_wdata_q <= wb_rf_wdata;
            end
            unique case (state_q)
                StRun: begin
                    if (end_hit) begin
                        done_q <= 1'b1;
                        if (end_ok) begin
                            state_q <= StPass;
                            pass_q  <= 1'b1;
                            leds_q  <= LED_PASS;
                        end else begin
                            state_q <= StFail;
                            fail_q  <= 1'b1;
                            code_q  <= end_code;
                            leds_q  <= fail_leds(end_code, ec_d[7:0]);
                        end
                    end else if (overrun) begin
                        state_q <= StFail;
                        fail_q  <= 1'b1;
                        done_q  <= 1'b1;
                        code_q  <= FcOverrun;
                        leds_q  <= fail_leds(FcOverrun, ec_d[7:0]);
                    end else if (tmo_hit) begin
                        state_q <= StFail;
                        fail_q  <= 1'b1;
                        done_q  <= 1'b1;
                        code_q  <= FcTimeout;
                        leds_q  <= fail_leds(FcTimeout, ec_d[7:0]);
                    end else if (stop_hit) begin
                        state_q <= StFail;
                        fail_q  <= 1'b1;
                        done_q  <= 1'b1;
                        code_q  <= FcMismatch;
                        leds_q  <= fail_leds(FcMismatch, ec_d[7:0]);
                    end
                end
                default: begin
                    // Pass and fail are sticky until reset.
                end
            endcase
        end
    end

    assign trace_idx   = idx_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign fail_code   = code_q;
    assign match_count = mc_q;
    assign err_count   = ec_q;
    assign err_pc      = err_pc_q;
    assign err_addr    = err_addr_q;
    assign err_wdata   = err_wdata_q;
    assign leds        = leds_q;

endmodule
